// File: rtl/pic_ack_sequencer.sv
// Interrupt controller core: IRR/ISR, fixed priority (IR0 highest), two-pulse INTA
// handshake with a vector byte on the second pulse, plus EOI and spurious handling.
module pic_ack_sequencer #(
    parameter int  NUM_IRQ = 8,
    parameter int  DATA_W  = 8,
    localparam int IDX_W   = (NUM_IRQ <= 2) ? 1 : $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] ir_req,
    input  logic [NUM_IRQ-1:0] imr,
    input  logic               edge_mode,
    input  logic               auto_eoi,
    input  logic [DATA_W-1:0]  vector_base,
    input  logic               inta_n,
    input  logic               eoi_valid,
    input  logic               eoi_specific,
    input  logic [IDX_W-1:0]   eoi_level,
    output logic               int_out,
    output logic [DATA_W-1:0]  data_out,
    output logic               data_oe,
    output logic [NUM_IRQ-1:0] irr,
    output logic [NUM_IRQ-1:0] isr,
    output logic [1:0]         o_dbg_state
);
    // Handshake: no valid/ready pairs here; inta_n is an asynchronous level that is
    // synchronised, and eoi_valid is a single-cycle strobe acted on in the cycle it is high.
    typedef enum logic [1:0] {S_IDLE, S_ACK1, S_WAIT2, S_ACK2} state_t;

    state_t              r_state, w_next;
    logic                r_inta_s1, r_inta_s2, r_inta_d;
    logic                w_fe, w_re;
    logic [NUM_IRQ-1:0]  r_irr, r_isr, r_ir_prev;
    logic [NUM_IRQ-1:0]  w_cand, w_ack_mask, w_isr_next, w_isr_low, w_irr_next;
    logic [IDX_W-1:0]    w_win, r_idx;
    logic                w_found, w_isr_block, w_win_valid;
    logic                r_spurious, r_int_out, r_data_oe;
    logic [DATA_W-1:0]   r_data_out;
    logic                w_ack1_entry, w_ack2_entry, w_ack2_exit, w_int_set, w_take;
    logic                w_unused;

    assign w_unused = ^vector_base[IDX_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inta_s1 <= 1'b1;
            r_inta_s2 <= 1'b1;
            r_inta_d  <= 1'b1;
        end else begin
            r_inta_s1 <= inta_n;
            r_inta_s2 <= r_inta_s1;
            r_inta_d  <= r_inta_s2;
        end
    end

    assign w_fe = r_inta_d & ~r_inta_s2;
    assign w_re = ~r_inta_d & r_inta_s2;

    // A winner is only valid if no in-service level of equal or higher priority exists.
    always_comb begin
        w_cand      = r_irr & ~imr;
        w_win       = '0;
        w_found     = 1'b0;
        w_isr_block = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_win   = IDX_W'(i);
                w_found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (r_isr[i] && (IDX_W'(i) <= w_win)) w_isr_block = 1'b1;
        end
        w_win_valid = w_found & ~w_isr_block;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_fe) w_next = S_ACK1;
            S_ACK1:  if (w_re) w_next = S_WAIT2;
            S_WAIT2: if (w_fe) w_next = S_ACK2;
            S_ACK2:  if (w_re) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ack1_entry = (r_state == S_IDLE)  && w_fe;
        w_ack2_entry = (r_state == S_WAIT2) && w_fe;
        w_ack2_exit  = (r_state == S_ACK2)  && w_re;
        w_int_set    = (r_state == S_IDLE)  && w_win_valid;
        w_take       = w_ack1_entry && w_win_valid;
        o_dbg_state  = r_state;
    end

    assign w_ack_mask = w_take ? (NUM_IRQ'(1) << w_win) : '0;
    assign w_irr_next = (edge_mode ? (r_irr | (ir_req & ~r_ir_prev)) : ir_req) & ~w_ack_mask;
    assign w_isr_low  = r_isr & (~r_isr + NUM_IRQ'(1));

    // Clears first, then the acknowledge set, so a same-bit set beats any EOI.
    always_comb begin
        w_isr_next = r_isr;
        if (eoi_valid) begin
            if (eoi_specific) begin
                for (int i = 0; i < NUM_IRQ; i++) begin
                    if (eoi_level == IDX_W'(i)) w_isr_next[i] = 1'b0;
                end
            end else begin
                w_isr_next = w_isr_next & ~w_isr_low;
            end
        end
        if (w_ack2_exit && auto_eoi && !r_spurious) w_isr_next = w_isr_next & ~(NUM_IRQ'(1) << r_idx);
        w_isr_next = w_isr_next | w_ack_mask;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irr      <= '0;
            r_isr      <= '0;
            r_ir_prev  <= '0;
            r_idx      <= '0;
            r_spurious <= 1'b0;
            r_int_out  <= 1'b0;
            r_data_out <= '0;
            r_data_oe  <= 1'b0;
        end else begin
            r_irr     <= w_irr_next;
            r_isr     <= w_isr_next;
            r_ir_prev <= ir_req;
            if (w_ack1_entry) begin
                r_idx      <= w_win_valid ? w_win : IDX_W'(NUM_IRQ - 1);
                r_spurious <= ~w_win_valid;
            end
            if (w_ack1_entry)   r_int_out <= 1'b0;
            else if (w_int_set) r_int_out <= 1'b1;
            if (w_ack2_entry) begin
                r_data_out <= {vector_base[DATA_W-1:IDX_W], r_idx};
                r_data_oe  <= 1'b1;
            end else if (w_ack2_exit) begin
                r_data_oe  <= 1'b0;
            end
        end
    end

    assign irr      = r_irr;
    assign isr      = r_isr;
    assign int_out  = r_int_out;
    assign data_out = r_data_out;
    assign data_oe  = r_data_oe;

endmodule

// File: doc/pic_ack_sequencer.md
Name: pic_ack_sequencer

Overview:
- Clocked, parametrised successor of the interrupt control logic. Holds the request register (IRR) and in-service register (ISR), and uses the mask (IMR) supplied from outside.
- Resolves fixed priority (IR0 highest), raises int_out and runs the two-pulse INTA handshake. On the second pulse it drives the vector byte for the data bus buffer.
- Supports edge or level triggering, auto-EOI, specific and non-specific EOI, and spurious-interrupt handling.
- Sits between the IR pins/command decoder and the data bus buffer.

Parameters:
- NUM_IRQ, 8, number of request lines (2..8). IDX_W = clog2(NUM_IRQ), minimum 1.
- DATA_W, 8, vector/data width. Must be at least IDX_W+1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset. Clears all state.
- ir_req  in  NUM_IRQ  request lines, synchronous to clk.
- imr  in  NUM_IRQ  mask. 1 = masked.
- edge_mode  in  1  1 = rising-edge triggered, 0 = level triggered.
- auto_eoi  in  1  1 = clear the ISR bit at the end of the second INTA.
- vector_base  in  DATA_W  upper vector bits. Bits [IDX_W-1:0] are ignored.
- inta_n  in  1  CPU acknowledge, asynchronous, active-low.
- eoi_valid  in  1  one-cycle EOI command strobe.
- eoi_specific  in  1  1 = specific EOI, 0 = non-specific.
- eoi_level  in  IDX_W  target level for a specific EOI.
- int_out  out  1  interrupt request to the CPU.
- data_out  out  DATA_W  vector byte.
- data_oe  out  1  1 = drive data_out onto the bus (direction = read).
- irr  out  NUM_IRQ  request register.
- isr  out  NUM_IRQ  in-service register.

Behaviour:
- Reset (asynchronous assert, release on clk): irr=0, isr=0, int_out=0, data_out=0, data_oe=0, FSM=IDLE, synchroniser=11, ir_prev=0.
- inta_n synchronisation: 2-flop synchroniser, then edge detect on the synchronised value. A falling edge (fe) or rising edge (re) is a 1-cycle internal pulse, 3 clk after the pin transition.
- IRR update:
  - Edge mode: bit i is set when ir_req[i]=1 and ir_prev[i]=0.
  - Level mode: irr[i] follows ir_req[i] every cycle.
  - In both modes a bit is cleared when it is acknowledged at ACK1. In level mode the next cycle re-samples ir_req.
  - ir_prev is registered every cycle.
- Resolution, combinational:
  - cand = irr & ~imr.
  - win = lowest index set in cand.
  - Valid only if no isr bit at index <= win is set.
- int_out is registered: set one cycle after a valid win exists while FSM=IDLE, cleared on ACK1 entry. Latency from an ir_req edge to int_out: 2 clk.
- FSM:
  - IDLE: wait for fe. On fe go to ACK1, regardless of int_out (CPU-initiated acknowledge).
  - ACK1, entered on fe:
    - If win is valid: latch idx=win, set isr[idx], clear irr[idx].
    - Otherwise: latch idx=NUM_IRQ-1 and set spurious=1; ISR is unchanged.
    - int_out=0. data_oe stays 0. Wait for re, then go to WAIT2.
  - WAIT2: wait for fe, then go to ACK2.
  - ACK2:
    - data_out = {vector_base[DATA_W-1:IDX_W], idx}, data_oe=1. Both are registered on the cycle after fe and held until re.
    - On re: data_oe=0, data_out holds its value.
    - On re, if auto_eoi=1 and spurious=0: clear isr[idx].
    - Then go to IDLE.
- EOI, applied in any state on eoi_valid:
  - Specific EOI clears isr[eoi_level]. An eoi_level >= NUM_IRQ is ignored.
  - Non-specific EOI clears the lowest-index set isr bit. If isr=0 it does nothing.
- Simultaneous events:
  - ACK1 set and EOI clear on the same bit in the same cycle: the set wins.
  - Different bits: both take effect.
  - In edge mode, an IRR set and an ACK1 clear on the same bit in the same cycle: the clear wins, and the edge is lost.
- Masking a pending request after int_out is asserted: int_out stays high until ACK1. ACK1 then resolves as spurious if nothing is valid.
- Reset mid-handshake: returns to IDLE immediately with data_oe=0. Later INTA pulses start a new sequence at ACK1.
- Nested operation: a higher-priority request may win while a lower isr bit is set. int_out reasserts from IDLE.

Test Plan:
- Edge mode, NUM_IRQ=8, vector_base=8'h40, ir_req[3] rises, imr=0 -> irr=8'h08 after 1 clk, int_out=1 after 2 clk. Two INTA pulses -> isr=8'h08, irr=0, data_out=8'h43 with data_oe=1 only during the second pulse.
- ir_req[5] and ir_req[2] rise in the same cycle -> first sequence vector 8'h42, isr=8'h04. Non-specific EOI -> isr=0. int_out reasserts; second sequence vector 8'h45.
- Request IR4 masked via imr=8'h10 -> int_out stays 0. Unmask -> int_out=1 within 1 clk.
- Level mode, ir_req[1] dropped after int_out but before the first INTA -> spurious: data_out=8'h47, isr=0.
- auto_eoi=1 with IR6 -> isr[6] set at ACK1 and cleared at the second INTA rising edge. Specific EOI for level 6 while isr[6]=0 -> no change.
- reset_n pulsed low during WAIT2 -> all outputs 0 immediately. The next two INTA pulses with IR0 pending -> vector 8'h40.
- Parameter sweep NUM_IRQ=4, DATA_W=8, vector_base=8'hA0, IR3 pending -> vector 8'hA3.
